aes_enc_core_nios2_gen2_0_cpu_ocimem_arbiter: RTL and testbench
===============================================================

# aes_enc_core_nios2_gen2_0_cpu_ocimem_arbiter

Shares the Nios II on-chip debug memory (OCI RAM, single port, 256×32, registered read) between two requesters. One is the JTAG debug-slave command strobes (`take_*_ocimem_*` with the `jdo` payload). The other is the CPU's Avalon debug-memory slave port. The block converts JTAG strobes into RAM reads and writes, returns read data through `MonDReg`, and arbitrates fairly against CPU traffic. It sits between the debug-slave sysclk logic and the OCI RAM instance in the CPU's debug module.

## Interface
- `ADDR_W`, 8, OCI RAM word-address width.
- `DATA_W`, 32, RAM data width. Fixed at 32; `jdo` field positions depend on it.
- `clk` in 1: system clock; every flop is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `jdo` in 38: JTAG payload. Address is `jdo[17:10]`; write data is `jdo[34:3]`.
- `take_action_ocimem_a` in 1: one-cycle strobe; load the JTAG address and read it.
- `take_no_action_ocimem_a` in 1: one-cycle strobe; read at the current JTAG address, then post-increment.
- `take_action_ocimem_b` in 1: one-cycle strobe; write data to the JTAG address, then post-increment.
- `cpu_address` in ADDR_W, `cpu_read` in 1, `cpu_write` in 1, `cpu_writedata` in 32, `cpu_byteenable` in 4: CPU Avalon request.
- `cpu_waitrequest` out 1: CPU request not accepted this cycle.
- `cpu_readdata` out 32: CPU read data, valid with `cpu_readdatavalid`.
- `cpu_readdatavalid` out 1: one-cycle pulse marking CPU read data.
- `ram_addr` out ADDR_W, `ram_wren` out 1, `ram_wdata` out 32, `ram_byteen` out 4: RAM port.
- `ram_rdata` in 32: RAM read data, valid one cycle after the address is presented.
- `MonDReg` out 32: last JTAG read result.
- `monitor_ready` out 1: high when no JTAG command is pending or in flight.
- `monitor_error` out 1: sticky JTAG overrun flag.

## Operation
- **JTAG command latch:** one-deep. A strobe in cycle T sets `pending` and the command kind at T+1, and clears `monitor_ready` at T+1.
  - Address load: `take_action_ocimem_a` also loads `jtag_addr <= jdo[17:10]` at T+1.
  - Multiple strobes in one cycle: priority order is `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. The losers are dropped and `monitor_error` is set.
  - Strobe while `pending` or in flight: the strobe is dropped and `monitor_error` is set.
  - Clearing `monitor_error`: it clears only on `reset`.
- **FSM states:** IDLE, JTAG_RD, CPU_RD.
- **IDLE arbitration:** requesters are JTAG (`pending`) and CPU (`cpu_read` | `cpu_write`).
  - One requester: it is granted.
  - Both requesters: the one not granted last is granted. `last_grant` resets to CPU, so JTAG wins the first tie.
  - A grant is never preempted.
- **JTAG write grant:** drives `ram_wren=1`, `ram_byteen=4'hF`, `ram_wdata=jdo_wdata_latched` (captured at strobe time).
  - Same cycle: `jtag_addr` increments.
  - Next cycle: `pending` clears and `monitor_ready` sets. FSM stays in IDLE.
- **JTAG read grant:** drives the address; next state is JTAG_RD.
  - In JTAG_RD: `MonDReg <= ram_rdata`, `pending` clears, `monitor_ready` sets, and `jtag_addr` increments only for `take_no_action_ocimem_a`. Return to IDLE.
- **CPU grant:** `cpu_waitrequest=0` in the grant cycle.
  - CPU write: completes in that cycle.
  - CPU read: next state is CPU_RD. There, `cpu_readdatavalid=1` and `cpu_readdata=ram_rdata`, then return to IDLE.
- **CPU waitrequest:** `cpu_waitrequest=1` whenever a CPU request is present and not granted, including during JTAG_RD and CPU_RD.
- **Address wrap:** `jtag_addr` wraps from 8'hFF to 8'h00.
- **Reset:** takes effect in any state, including mid-read. State returns to IDLE, and `pending` and `last_grant` are cleared.
  - Output reset values: `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0, `cpu_readdatavalid`=0, `ram_wren`=0, `cpu_waitrequest`=0.
  - An interrupted read produces no `cpu_readdatavalid` pulse.

## Timing
- JTAG read: strobe at T, grant at T+1 if idle, `MonDReg` and `monitor_ready` valid at T+3.
- JTAG write: strobe at T, RAM write at T+1, `monitor_ready` at T+2.
- CPU read: accepted at G, data at G+1. CPU write: accepted at G.
- Worst-case CPU wait behind JTAG: 2 cycles (one JTAG read).
- RAM outputs are combinational from state, `pending` and the grant decision. `ram_wren` is never asserted outside a write grant.

## Structure
- **Package `aes_enc_core_ocimem_pkg`:** the FSM state enum, the JTAG command enum (NONE/RD_LOAD/RD_INC/WR_INC), `jdo` field constants (ADDR_LSB=10, WDATA_LSB=3), and the grant-owner type.
- **Sub-module `aes_enc_core_ocimem_jtag_cmd_latch`:** strobe priority, pending flag, address register/increment, write-data capture and overrun flag. Arbitration and the FSM stay in the top.

## Test plan
- **JTAG load read:** RAM[8'h20]=32'hDEADBEEF; pulse `take_action_ocimem_a` with `jdo[17:10]`=8'h20 -> `MonDReg`=32'hDEADBEEF at T+3, `monitor_ready` 0 then 1, `jtag_addr` stays 8'h20.
- **JTAG write and wrap:** load address 8'hFF, then `take_action_ocimem_b` with `jdo[34:3]`=32'h12345678 -> RAM[FF]=32'h12345678; a following `take_no_action_ocimem_a` reads RAM[00].
- **Tie alternation:** `pending` JTAG read plus continuous CPU reads -> grants go JTAG, CPU, JTAG… after reset; CPU wait never exceeds 2 cycles.
- **CPU write then read:** write 32'hA5A5_0F0F with byteenable 4'b0011 to 8'h10 (old 32'hFFFFFFFF) -> read returns 32'hFFFF0F0F, `cpu_readdatavalid` one cycle after accept.
- **Overrun:** `take_no_action_ocimem_a` while `pending`, or two strobes in one cycle -> `monitor_error`=1 and sticky; only the first command executes.
- **Reset mid-read:** assert `reset` in CPU_RD or JTAG_RD -> no `cpu_readdatavalid`, `MonDReg`=0, `monitor_ready`=1 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/aes_enc_core_ocimem_pkg.sv
// Shared types and constants for the OCI RAM arbiter: FSM state encodings,
// JTAG command kinds, grant owner and the bit positions inside jdo.
package aes_enc_core_ocimem_pkg;

    // Width of the JTAG debug-slave payload and where its fields live.
    localparam int JDO_W     = 38;
    localparam int ADDR_LSB  = 10;   // jdo[17:10] carries the word address
    localparam int WDATA_LSB = 3;    // jdo[34:3] carries the write data

    // Arbiter FSM state encodings; kept as plain constants so the state
    // register can be exported as a raw 2-bit debug value.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_JTAG_RD = 2'd1;
    localparam state_t ST_CPU_RD  = 2'd2;

    // Kind of JTAG command held in the one-deep command latch.
    typedef enum logic [1:0] {
        CMD_NONE    = 2'd0,
        CMD_RD_LOAD = 2'd1,   // load address from jdo, read it, no increment
        CMD_RD_INC  = 2'd2,   // read current address, then post-increment
        CMD_WR_INC  = 2'd3    // write captured data, then post-increment
    } jtag_cmd_t;

    // Owner of the most recent RAM grant, used to break ties fairly.
    typedef enum logic {
        GRANT_CPU  = 1'b0,
        GRANT_JTAG = 1'b1
    } grant_t;

endpackage

// File: rtl/aes_enc_core_ocimem_jtag_cmd_latch.sv
// One-deep JTAG command latch. Turns the take_* strobes into a pending
// command, owns the auto-incrementing JTAG address and the captured write
// data, and raises a sticky overrun flag when a strobe has to be dropped.
module aes_enc_core_ocimem_jtag_cmd_latch
    import aes_enc_core_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              wr_done,        // JTAG write granted this cycle
    input  logic              rd_done,        // JTAG read data returning this cycle
    output logic              pending,
    output logic [1:0]        cmd,
    output logic [ADDR_W-1:0] jtag_addr,
    output logic [DATA_W-1:0] wdata,
    output logic              monitor_error
);

    logic      any_strobe;
    logic      multi_strobe;
    logic      accept;
    logic      overrun;
    jtag_cmd_t cmd_next;
    jtag_cmd_t cmd_q;

    logic [ADDR_W-1:0] jdo_addr;
    logic [DATA_W-1:0] jdo_wdata;
    logic              unused_jdo_bits;

    assign jdo_addr  = jdo[ADDR_LSB +: ADDR_W];
    assign jdo_wdata = jdo[WDATA_LSB +: DATA_W];
    // jdo carries control bits outside the two payload fields that this
    // block never looks at.
    assign unused_jdo_bits = ^{jdo[JDO_W-1:WDATA_LSB+DATA_W], jdo[WDATA_LSB-1:0]};

    // A command is only taken when the latch is empty; anything else that
    // arrives (a second strobe in the same cycle, or a strobe while the
    // previous command is still pending or in flight) is lost and flagged.
    assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b)
                        | (take_action_ocimem_a & take_no_action_ocimem_a)
                        | (take_action_ocimem_b & take_no_action_ocimem_a);
    assign accept       = any_strobe & ~pending;
    assign overrun      = (any_strobe & pending) | multi_strobe;

    // Strobe priority: address load beats write beats read-increment.
    always_comb begin
        cmd_next = CMD_NONE;
        if (take_action_ocimem_a) begin
            cmd_next = CMD_RD_LOAD;
        end else if (take_action_ocimem_b) begin
            cmd_next = CMD_WR_INC;
        end else if (take_no_action_ocimem_a) begin
            cmd_next = CMD_RD_INC;
        end
    end

    // Command latch, JTAG address register and write-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= 1'b0;
            cmd_q     <= CMD_NONE;
            jtag_addr <= '0;
            wdata     <= '0;
        end else if (accept) begin
            pending <= 1'b1;
            cmd_q   <= cmd_next;
            if (cmd_next == CMD_RD_LOAD) begin
                jtag_addr <= jdo_addr;
            end
            if (cmd_next == CMD_WR_INC) begin
                wdata <= jdo_wdata;
            end
        end else if (wr_done) begin
            pending   <= 1'b0;
            jtag_addr <= jtag_addr + 1'b1;   // wraps 8'hFF -> 8'h00
        end else if (rd_done) begin
            pending <= 1'b0;
            if (cmd_q == CMD_RD_INC) begin
                jtag_addr <= jtag_addr + 1'b1;
            end
        end
    end

    // Sticky overrun flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            monitor_error <= 1'b0;
        end else if (overrun) begin
            monitor_error <= 1'b1;
        end
    end

    assign cmd = cmd_q;

endmodule

// File: rtl/aes_enc_core_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG debug-slave commands
// and the CPU's Avalon debug-memory port. Ties alternate between the two
// requesters; a grant always runs to completion.
//
// CPU handshake: a request (cpu_read or cpu_write) is accepted on a rising
// edge where cpu_waitrequest is low; the master holds address/data stable
// until then. Read data arrives exactly one cycle after acceptance, marked
// by a single-cycle cpu_readdatavalid pulse.
module aes_enc_core_nios2_gen2_0_cpu_ocimem_arbiter
    import aes_enc_core_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [JDO_W-1:0]    jdo,
    input  logic                take_action_ocimem_a,
    input  logic                take_no_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    input  logic [ADDR_W-1:0]   cpu_address,
    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [DATA_W-1:0]   cpu_writedata,
    input  logic [DATA_W/8-1:0] cpu_byteenable,
    output logic                cpu_waitrequest,
    output logic [DATA_W-1:0]   cpu_readdata,
    output logic                cpu_readdatavalid,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_wren,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_byteen,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [DATA_W-1:0]   MonDReg,
    output logic                monitor_ready,
    output logic                monitor_error,
    output logic [1:0]          fsm_state
);

    state_t state;
    state_t state_next;
    grant_t last_grant;

    logic              pending;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] jtag_addr;
    logic [DATA_W-1:0] jtag_wdata;

    logic cpu_req;
    logic cpu_is_read;
    logic grant_jtag;
    logic grant_cpu;
    logic jtag_is_write;
    logic wr_done;
    logic rd_done;

    aes_enc_core_ocimem_jtag_cmd_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmd_latch (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .wr_done                 (wr_done),
        .rd_done                 (rd_done),
        .pending                 (pending),
        .cmd                     (cmd),
        .jtag_addr               (jtag_addr),
        .wdata                   (jtag_wdata),
        .monitor_error           (monitor_error)
    );

    assign cpu_req       = cpu_read | cpu_write;
    // A master asserting both strobes is treated as a write.
    assign cpu_is_read   = cpu_read & ~cpu_write;
    assign jtag_is_write = (cmd == CMD_WR_INC);

    // Arbitration happens only in IDLE; on a tie the side that did not win
    // last time gets the RAM.
    always_comb begin
        grant_jtag = 1'b0;
        grant_cpu  = 1'b0;
        if (state == ST_IDLE) begin
            if (pending && (!cpu_req || last_grant == GRANT_CPU)) begin
                grant_jtag = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end
        end
    end

    assign wr_done = grant_jtag & jtag_is_write;
    assign rd_done = (state == ST_JTAG_RD);

    // Next-state logic: reads spend one extra cycle waiting for RAM data,
    // writes complete inside the grant cycle.
    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (grant_jtag && !jtag_is_write) begin
                    state_next = ST_JTAG_RD;
                end else if (grant_cpu && cpu_is_read) begin
                    state_next = ST_CPU_RD;
                end
            end
            ST_JTAG_RD: state_next = ST_IDLE;
            ST_CPU_RD:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // State register and tie-break memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_CPU;
        end else begin
            state <= state_next;
            if (grant_jtag) begin
                last_grant <= GRANT_JTAG;
            end else if (grant_cpu) begin
                last_grant <= GRANT_CPU;
            end
        end
    end

    // RAM port mux: the JTAG side always writes whole words.
    always_comb begin
        ram_addr   = cpu_address;
        ram_wdata  = cpu_writedata;
        ram_byteen = cpu_byteenable;
        ram_wren   = 1'b0;
        if (grant_jtag) begin
            ram_addr   = jtag_addr;
            ram_wdata  = jtag_wdata;
            ram_byteen = '1;
            ram_wren   = jtag_is_write;
        end else if (grant_cpu) begin
            ram_wren = cpu_write;
        end
    end

    // Capture JTAG read data as it comes back from the RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            MonDReg <= '0;
        end else if (rd_done) begin
            MonDReg <= ram_rdata;
        end
    end

    // The valid pulse is masked by reset so a read interrupted in CPU_RD
    // never reports data.
    assign cpu_waitrequest   = cpu_req & ~grant_cpu;
    assign cpu_readdatavalid = (state == ST_CPU_RD) & ~reset;
    assign cpu_readdata      = cpu_readdatavalid ? ram_rdata : '0;
    assign monitor_ready     = ~pending;
    assign fsm_state         = state;

endmodule

// File: tb/tb_aes_enc_core_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter with a behavioural 256x32
// registered-read RAM and a queue of expected CPU read data.
module tb_aes_enc_core_nios2_gen2_0_cpu_ocimem_arbiter;
    import aes_enc_core_ocimem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic        cpu_waitrequest;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [1:0]  fsm_state;

    aes_enc_core_nios2_gen2_0_cpu_ocimem_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_waitrequest         (cpu_waitrequest),
        .cpu_readdata            (cpu_readdata),
        .cpu_readdatavalid       (cpu_readdatavalid),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_wdata               (ram_wdata),
        .ram_byteen              (ram_byteen),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .fsm_state               (fsm_state)
    );

    // ---------------- RAM model ----------------
    logic [31:0] mem [0:255];
    logic        ram_init;

    function automatic logic [31:0] init_word(input logic [7:0] a);
        case (a)
            8'h20:   return 32'hDEADBEEF;
            8'h10:   return 32'hFFFFFFFF;
            default: return {24'h5A0000, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i[7:0]);
            ram_rdata <= '0;
        end else begin
            if (ram_wren) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // CPU read data is compared when the DUT marks it valid.
    always @(negedge clk) begin
        if (cpu_readdatavalid) begin
            if (exp_q.size() == 0) begin
                check("cpu_rd_unexpected", {31'd0, cpu_readdatavalid}, 32'd0);
            end else begin
                check("cpu_rd_data", cpu_readdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a);
        logic [37:0] j;
        j = '0;
        j[17:10] = a;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // kind: 0 = load/read (a), 1 = write (b), 2 = read/increment (no_action_a)
    task automatic jtag(input int kind, input logic [37:0] payload);
        jdo = payload;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!monitor_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_timeout", {31'd0, monitor_ready}, 32'd1);
    endtask

    task automatic do_cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        cpu_address = a;
        cpu_writedata = d;
        cpu_byteenable = be;
        cpu_write = 1'b1;
        #1;
        while (cpu_waitrequest && n < 10) begin
            tick();
            n++;
        end
        check("cpu_wr_accept", {31'd0, cpu_waitrequest}, 32'd0);
        tick();
        cpu_write = 1'b0;
    endtask

    task automatic do_cpu_read(input logic [7:0] a, input logic [31:0] exp);
        int n = 0;
        cpu_address = a;
        cpu_read = 1'b1;
        #1;
        while (cpu_waitrequest && n < 10) begin
            tick();
            n++;
        end
        check("cpu_rd_accept", {31'd0, cpu_waitrequest}, 32'd0);
        exp_q.push_back(exp);
        tick();
        cpu_read = 1'b0;
        #1;
        check("cpu_rd_latency", {31'd0, cpu_readdatavalid}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        ram_init = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        cpu_address = '0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_writedata = '0;
        cpu_byteenable = '0;
        tick(); tick(); tick();
        ram_init = 1'b0;
        reset = 1'b0;
        #1;

        // reset values
        check("rst_mondreg", MonDReg, 32'd0);
        check("rst_ready", {31'd0, monitor_ready}, 32'd1);
        check("rst_error", {31'd0, monitor_error}, 32'd0);
        check("rst_rdvalid", {31'd0, cpu_readdatavalid}, 32'd0);
        check("rst_wren", {31'd0, ram_wren}, 32'd0);
        check("rst_waitreq", {31'd0, cpu_waitrequest}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});

        // JTAG load read of 8'h20
        jtag(0, jdo_a(8'h20));
        #1;
        check("jrd_ready_low", {31'd0, monitor_ready}, 32'd0);
        check("jrd_ram_addr", {24'd0, ram_addr}, 32'h20);
        check("jrd_no_wren", {31'd0, ram_wren}, 32'd0);
        tick();
        check("jrd_state", {30'd0, fsm_state}, {30'd0, ST_JTAG_RD});
        tick();
        check("jrd_mondreg", MonDReg, 32'hDEADBEEF);
        check("jrd_ready_high", {31'd0, monitor_ready}, 32'd1);
        jtag(2, '0);
        wait_ready();
        check("jrd_addr_held", MonDReg, 32'hDEADBEEF);
        jtag(2, '0);
        wait_ready();
        check("jrd_addr_inc", MonDReg, 32'h5A000021);

        // JTAG write at 8'hFF and wrap to 8'h00
        jtag(0, jdo_a(8'hFF));
        wait_ready();
        check("wr_load_ff", MonDReg, 32'h5A0000FF);
        jtag(1, jdo_b(32'h12345678));
        #1;
        check("wr_wren", {31'd0, ram_wren}, 32'd1);
        check("wr_addr", {24'd0, ram_addr}, 32'hFF);
        check("wr_wdata", ram_wdata, 32'h12345678);
        check("wr_byteen", {28'd0, ram_byteen}, 32'hF);
        check("wr_ready_low", {31'd0, monitor_ready}, 32'd0);
        tick();
        check("wr_ready_high", {31'd0, monitor_ready}, 32'd1);
        check("wr_ram_ff", mem[8'hFF], 32'h12345678);
        jtag(2, '0);
        wait_ready();
        check("wr_wrap_read", MonDReg, 32'h5A000000);

        // CPU byte-enabled write then read
        do_cpu_write(8'h10, 32'hA5A50F0F, 4'b0011);
        check("cpu_wr_ram", mem[8'h10], 32'hFFFF0F0F);
        do_cpu_read(8'h10, 32'hFFFF0F0F);
        tick();

        // tie alternation: JTAG first after reset, CPU waits 2 cycles max
        apply_reset();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        cpu_address = 8'h10;
        cpu_read = 1'b1;
        for (int r = 0; r < 3; r++) begin
            #1;
            check("tie_jtag_wins", {31'd0, cpu_waitrequest}, 32'd1);
            check("tie_jtag_addr", {24'd0, ram_addr}, r);
            tick();
            check("tie_jrd_state", {30'd0, fsm_state}, {30'd0, ST_JTAG_RD});
            check("tie_wait_jrd", {31'd0, cpu_waitrequest}, 32'd1);
            tick();
            check("tie_cpu_grant", {31'd0, cpu_waitrequest}, 32'd0);
            check("tie_mondreg", MonDReg, 32'h5A000000 + r);
            exp_q.push_back(32'hFFFF0F0F);
            take_no_action_ocimem_a = (r < 2);
            tick();
            take_no_action_ocimem_a = 1'b0;
            cpu_read = (r < 2);
            #1;
            check("tie_cpurd_valid", {31'd0, cpu_readdatavalid}, 32'd1);
            check("tie_wait_cpurd", {31'd0, cpu_waitrequest}, (r < 2) ? 32'd1 : 32'd0);
            tick();
        end

        // overrun: strobe while pending
        apply_reset();
        check("ovr_clear0", {31'd0, monitor_error}, 32'd0);
        jtag(0, jdo_a(8'h40));
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        check("ovr_pending_err", {31'd0, monitor_error}, 32'd1);
        wait_ready();
        check("ovr_first_cmd", MonDReg, 32'h5A000040);
        jtag(2, '0);
        wait_ready();
        check("ovr_dropped_noinc", MonDReg, 32'h5A000040);
        check("ovr_sticky", {31'd0, monitor_error}, 32'd1);

        // overrun: two strobes in one cycle, load wins
        apply_reset();
        check("ovr_reset_clears", {31'd0, monitor_error}, 32'd0);
        jdo = jdo_a(8'h30);
        take_action_ocimem_a = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        check("multi_err", {31'd0, monitor_error}, 32'd1);
        wait_ready();
        check("multi_load_won", MonDReg, 32'h5A000030);
        jtag(2, '0);
        wait_ready();
        check("multi_addr_held", MonDReg, 32'h5A000030);
        jtag(2, '0);
        wait_ready();
        check("multi_addr_inc", MonDReg, 32'h5A000031);

        // reset during JTAG_RD
        jtag(0, jdo_a(8'h20));
        tick();
        check("rst_jrd_in_state", {30'd0, fsm_state}, {30'd0, ST_JTAG_RD});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_jrd_mondreg", MonDReg, 32'd0);
        check("rst_jrd_ready", {31'd0, monitor_ready}, 32'd1);
        check("rst_jrd_idle", {30'd0, fsm_state}, {30'd0, ST_IDLE});

        // reset during CPU_RD
        cpu_address = 8'h20;
        cpu_read = 1'b1;
        #1;
        check("rst_cpu_accept", {31'd0, cpu_waitrequest}, 32'd0);
        tick();
        cpu_read = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_cpurd_in_state", {30'd0, fsm_state}, {30'd0, ST_CPU_RD});
        check("rst_cpurd_no_valid", {31'd0, cpu_readdatavalid}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_cpurd_idle", {30'd0, fsm_state}, {30'd0, ST_IDLE});
        check("rst_cpurd_still_no_valid", {31'd0, cpu_readdatavalid}, 32'd0);
        tick();
        tick();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
